// File: rtl/arp_rx.sv
// Receive-side ARP parser: strips preamble/SFD, filters Ethernet/ARP headers
// against the board address, and latches the sender MAC/IP of accepted frames.
module arp_rx #(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02
) (
  input  logic        gmii_rx_clk,
  input  logic        rst,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HEAD,
    ARP_DATA,
    RX_END
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

  state_t      state;
  logic [4:0]  cnt;
  logic [47:0] dst_mac;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [23:0] tpa;
  logic [7:0]  prev_byte;
  logic        oper_bit;

  logic [15:0] field_now;
  logic [31:0] tpa_now;

  // 16-bit fields and the target IP are judged on their final byte, so
  // combine the registered history with the byte currently on the bus.
  assign field_now = {prev_byte, gmii_rxd};
  assign tpa_now   = {tpa, gmii_rxd};

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dst_mac     <= '0;
      sha         <= '0;
      spa         <= '0;
      tpa         <= '0;
      prev_byte   <= '0;
      oper_bit    <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      arp_rx_done <= 1'b0;
      prev_byte   <= gmii_rxd;
      case (state)
        IDLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55) begin
            state <= PREAMBLE;
            cnt   <= '0;
          end
        end
        PREAMBLE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (gmii_rxd == 8'h55 && cnt < 5'd6) begin
            cnt <= cnt + 5'd1;
          end else if (gmii_rxd == 8'hD5 && cnt == 5'd6) begin
            state <= ETH_HEAD;
            cnt   <= '0;
          end else begin
            state <= RX_END;
            cnt   <= '0;
          end
        end
        ETH_HEAD: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt < 5'd6) dst_mac <= {dst_mac[39:0], gmii_rxd};
            if (cnt == 5'd13) begin
              cnt <= '0;
              if (field_now == 16'h0806 && (dst_mac == BOARD_MAC || dst_mac == BCAST_MAC))
                state <= ARP_DATA;
              else
                state <= RX_END;
            end
          end
        end
        ARP_DATA: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            if ((cnt == 5'd1 && field_now != 16'h0001) ||
                (cnt == 5'd3 && field_now != 16'h0800) ||
                (cnt == 5'd4 && gmii_rxd != 8'h06) ||
                (cnt == 5'd5 && gmii_rxd != 8'h04) ||
                (cnt == 5'd7 && field_now != 16'h0001 && field_now != 16'h0002)) begin
              state <= RX_END;
              cnt   <= '0;
            end
            if (cnt == 5'd7) oper_bit <= gmii_rxd[1];
            if (cnt >= 5'd8 && cnt <= 5'd13) sha <= {sha[39:0], gmii_rxd};
            if (cnt >= 5'd14 && cnt <= 5'd17) spa <= {spa[23:0], gmii_rxd};
            if (cnt >= 5'd24 && cnt <= 5'd27) tpa <= tpa_now[23:0];
            if (cnt == 5'd27) begin
              state <= RX_END;
              cnt   <= '0;
              if (tpa_now == BOARD_IP) begin
                src_mac     <= sha;
                src_ip      <= spa;
                arp_rx_type <= oper_bit;
                arp_rx_done <= 1'b1;
              end
            end
          end
        end
        RX_END: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: frames are built byte by byte, accepted frames
// enqueue their expected done cycle and sender fields for the done monitor.
module tb_arp_rx;

  localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_02;
  localparam logic [47:0] BCAST     = 48'hff_ff_ff_ff_ff_ff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv  = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          cyc;
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  exp_t        exp_q[$];
  logic        exp_type = 1'b0;
  logic [47:0] exp_mac  = '0;
  logic [31:0] exp_ip   = '0;

  arp_rx dut (
    .gmii_rx_clk (clk),
    .rst         (rst),
    .gmii_rx_dv  (dv),
    .gmii_rxd    (rxd),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every done pulse must match the oldest outstanding accepted frame.
  always @(negedge clk) begin
    if (arp_rx_done === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_done: done=1 at cycle %0d, required no pulse", cyc);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks += 4;
        assert (cyc === e.cyc) else begin
          errors++;
          $error("FAIL done_cycle: got %0d, required %0d", cyc, e.cyc);
        end
        assert (arp_rx_type === e.typ) else begin
          errors++;
          $error("FAIL done_type: got %0b, required %0b", arp_rx_type, e.typ);
        end
        assert (src_mac === e.mac) else begin
          errors++;
          $error("FAIL done_mac: got %h, required %h", src_mac, e.mac);
        end
        assert (src_ip === e.ip) else begin
          errors++;
          $error("FAIL done_ip: got %h, required %h", src_ip, e.ip);
        end
      end
    end
  end

  task automatic check_outputs(input string tag);
    checks += 3;
    assert (arp_rx_type === exp_type) else begin
      errors++;
      $error("FAIL %s_type: got %0b, required %0b", tag, arp_rx_type, exp_type);
    end
    assert (src_mac === exp_mac) else begin
      errors++;
      $error("FAIL %s_mac: got %h, required %h", tag, src_mac, exp_mac);
    end
    assert (src_ip === exp_ip) else begin
      errors++;
      $error("FAIL %s_ip: got %h, required %h", tag, src_ip, exp_ip);
    end
  endtask

  task automatic push_bytes(inout logic [7:0] q[$], input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) q.push_back(v[k*8 +: 8]);
  endtask

  task automatic send_frame(input string tag, input logic [47:0] dst, input logic [15:0] etype,
                            input logic [15:0] oper, input logic [47:0] sha, input logic [31:0] spa,
                            input logic [31:0] tpa, input int pre_len, input bit bad_pre,
                            input int trunc, input int rst_idx);
    logic [7:0] q[$];
    int  n;
    bit  accept;
    for (int k = 0; k < pre_len; k++) q.push_back(8'h55);
    if (bad_pre) q[3] = 8'h54;
    q.push_back(8'hD5);
    push_bytes(q, {16'h0, dst}, 6);
    push_bytes(q, 64'h0000_DE_AD_BE_EF_00_01, 6);
    push_bytes(q, {48'h0, etype}, 2);
    push_bytes(q, 64'h0000_0000_0001_0800, 4);
    push_bytes(q, 64'h06, 1);
    push_bytes(q, 64'h04, 1);
    push_bytes(q, {48'h0, oper}, 2);
    push_bytes(q, {16'h0, sha}, 6);
    push_bytes(q, {32'h0, spa}, 4);
    push_bytes(q, 64'h0, 6);
    push_bytes(q, {32'h0, tpa}, 4);
    for (int k = 0; k < 18; k++) q.push_back(8'h00);
    push_bytes(q, {32'h0, $urandom()}, 4);
    n = (trunc >= 0) ? trunc : q.size();
    accept = (pre_len == 7) && !bad_pre && (trunc < 0) && (rst_idx < 0) &&
             (etype == 16'h0806) && (dst == BOARD_MAC || dst == BCAST) &&
             (oper == 16'h0001 || oper == 16'h0002) && (tpa == BOARD_IP);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      dv  = 1'b1;
      rxd = q[i];
      if (accept && i == 49) begin
        exp_type = oper[1];
        exp_mac  = sha;
        exp_ip   = spa;
        exp_q.push_back('{cyc: cyc + 1, typ: oper[1], mac: sha, ip: spa});
      end
      if (i == rst_idx) begin
        #2 rst = 1'b1;
        #1;
        exp_type = 1'b0;
        exp_mac  = '0;
        exp_ip   = '0;
        checks++;
        assert (arp_rx_done === 1'b0) else begin
          errors++;
          $error("FAIL rst_mid_done: got %0b, required 0", arp_rx_done);
        end
        check_outputs("rst_mid");
        rst = 1'b0;
      end
    end
    @(negedge clk);
    dv  = 1'b0;
    rxd = 8'h00;
    check_outputs(tag);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    assert (arp_rx_done === 1'b0) else begin
      errors++;
      $error("FAIL reset_done: got %0b, required 0", arp_rx_done);
    end
    check_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    send_frame("bcast_req", BCAST, 16'h0806, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A80003,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("ucast_reply", BOARD_MAC, 16'h0806, 16'h0002, 48'h02AABBCCDDEE, 32'hC0A80007,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("rej_tpa", BCAST, 16'h0806, 16'h0001, 48'h111111111111, 32'hC0A80011,
               32'hC0A80009, 7, 1'b0, -1, -1);
    send_frame("rej_etype", BCAST, 16'h0800, 16'h0001, 48'h222222222222, 32'hC0A80022,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("rej_dst", 48'h001122334466, 16'h0806, 16'h0001, 48'h333333333333, 32'hC0A80033,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("rej_oper", BOARD_MAC, 16'h0806, 16'h0003, 48'h444444444444, 32'hC0A80044,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("trunc", BCAST, 16'h0806, 16'h0001, 48'h555555555555, 32'hC0A80055,
               BOARD_IP, 7, 1'b0, 33, -1);
    send_frame("after_trunc", BCAST, 16'h0806, 16'h0001, 48'h0600DEADBEEF, 32'hC0A80066,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("bad_pre54", BCAST, 16'h0806, 16'h0002, 48'h777777777777, 32'hC0A80077,
               BOARD_IP, 7, 1'b1, -1, -1);
    send_frame("after_pre54", BOARD_MAC, 16'h0806, 16'h0002, 48'h08090A0B0C0D, 32'hC0A80088,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("short_pre", BCAST, 16'h0806, 16'h0001, 48'h999999999999, 32'hC0A80099,
               BOARD_IP, 5, 1'b0, -1, -1);
    send_frame("after_short", BCAST, 16'h0806, 16'h0001, 48'h0A1A2A3A4A5A, 32'hC0A800AA,
               BOARD_IP, 7, 1'b0, -1, -1);
    send_frame("rst_frame", BCAST, 16'h0806, 16'h0001, 48'hBBBBBBBBBBBB, 32'hC0A800BB,
               BOARD_IP, 7, 1'b0, -1, 12);
    send_frame("after_rst", BOARD_MAC, 16'h0806, 16'h0002, 48'h0C1C2C3C4C5C, 32'hC0A800CC,
               BOARD_IP, 7, 1'b0, -1, -1);

    repeat (4) @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_done: %0d pulses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arp_rx.md
# arp_rx

Receive-side ARP parser for the SGMII/GMII Ethernet path. It sits between the `sgmii_to_gmii` GMII receive outputs and `arp_ctrl`, and runs in the `gmii_rx_clk` domain. It strips preamble/SFD, checks the Ethernet header and ARP payload against the board's MAC/IP, and latches the sender's MAC/IP. It then pulses `arp_rx_done` with the opcode type, so the controller can answer requests or record replies.

## Interface
- `BOARD_MAC`, 48'h00_11_22_33_44_55, local MAC; destination MAC must equal this or 48'hff_ff_ff_ff_ff_ff.
- `BOARD_IP`, 32'hC0_A8_00_02, local IP; ARP target protocol address must equal this.

- `gmii_rx_clk` in 1: 125 MHz GMII receive clock; sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `gmii_rx_dv` in 1: GMII receive data valid.
- `gmii_rxd` in 8: GMII receive byte.
- `arp_rx_done` out 1: one-cycle pulse, valid ARP frame for this board parsed.
- `arp_rx_type` out 1: 0 = request (OPER 1), 1 = reply (OPER 2); held until next done.
- `src_mac` out 48: sender hardware address of last accepted frame.
- `src_ip` out 32: sender protocol address of last accepted frame.

## Operation
- States: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, RX_END. One 5-bit byte counter `cnt`, cleared on every state change.
- IDLE: on `dv`=1 and `rxd`=8'h55 -> PREAMBLE (this byte counts as preamble byte 1).
- PREAMBLE: expects six more 8'h55, then 8'hD5 -> ETH_HEAD.
  - Any other byte -> RX_END.
  - SFD before 7 preamble bytes total -> RX_END.
- ETH_HEAD: 14 bytes.
  - Bytes 0-5: destination MAC, shifted into a 48-bit register, MSB first.
  - Bytes 6-11: source MAC, ignored.
  - Bytes 12-13: EtherType.
  - At byte 13, the frame is accepted only if EtherType = 16'h0806 and the destination MAC equals BOARD_MAC or broadcast. Accept -> ARP_DATA; reject -> RX_END.
- ARP_DATA: 28 bytes; fields are checked on their last byte.
  - HTYPE 16'h0001, PTYPE 16'h0800, HLEN 8'h06, PLEN 8'h04.
  - OPER 16'h0001 or 16'h0002.
  - Any mismatch -> RX_END.
  - SHA (bytes 8-13) and SPA (bytes 14-17) shift into holding registers. THA (bytes 18-23) is ignored. TPA (bytes 24-27) shifts into a register.
- At byte 27, if TPA == BOARD_IP:
  - copy SHA -> `src_mac` and SPA -> `src_ip`;
  - set `arp_rx_type` from OPER bit 1;
  - pulse `arp_rx_done`;
  - go to RX_END.
- If TPA mismatches: go to RX_END with no outputs changed.
- RX_END: discard padding and FCS; wait for `dv`=0 -> IDLE. FCS is not checked.
- `dv` falling in PREAMBLE, ETH_HEAD or ARP_DATA -> IDLE immediately. No done pulse, outputs unchanged.
- `dv` rising in RX_END while still high is the same frame; a new frame needs at least one `dv`=0 cycle.
- Partially received sender fields never reach the outputs; they update only on accept.

## Timing
- Reset values: `arp_rx_done`=0, `arp_rx_type`=0, `src_mac`=48'h0, `src_ip`=32'h0, state IDLE, `cnt`=0, all holding registers 0.
- All outputs are registered.
- `arp_rx_done` goes high in the cycle after the clock edge that samples the last TPA byte (frame byte 49 counting from the first preamble byte as 0). It is high for exactly one cycle.
- `src_mac`, `src_ip` and `arp_rx_type` update on the same edge that raises `arp_rx_done`, and are stable from then on.
- Back-to-back frames with a 1-cycle `dv` gap are each parsed; no throughput limit beyond line rate.
- `rst` asserted mid-frame: registers clear asynchronously. After release the block waits in IDLE and the current frame's remaining bytes are ignored until the next preamble.

## Test plan
- Broadcast-destination ARP request:
  - Stimulus: SHA 0x0A0B0C0D0E0F, SPA 0xC0A80003, TPA 0xC0A80002, 18 pad bytes + FCS.
  - Required: one `arp_rx_done` pulse 1 cycle after TPA byte 3, `arp_rx_type`=0, `src_mac`=48'h0A0B0C0D0E0F, `src_ip`=32'hC0A80003.
- Unicast ARP reply to 00:11:22:33:44:55 with OPER 2:
  - Required: done pulse, `arp_rx_type`=1.
- Frames that must be rejected:
  - Stimulus: TPA 0xC0A80009, EtherType 0x0800, destination MAC 00:11:22:33:44:66 (one frame each).
  - Required: no done pulse; `src_mac`/`src_ip` keep their previous values.
- Truncated then valid:
  - Stimulus: `dv` dropped after ARP byte 10, then 1-cycle gap, then a valid request.
  - Required: exactly one done pulse, for the second frame only.
- Bad preamble:
  - Stimulus: preamble with one 0x54, or SFD after only 5 bytes of 0x55.
  - Required: no done pulse; the following good frame is accepted.
- Reset mid-frame:
  - Stimulus: `rst` pulsed during ETH_HEAD.
  - Required: outputs read 0 at once, no done for that frame, and the next frame is accepted normally.
